// File: rtl/timer_pkg.sv
// Shared definitions for the 8-bit timer: clock-select codes, widths
// and the divider tap test used by the prescaler.
package timer_pkg;

    localparam int DIV_W = 4;
    localparam int CKS_W = 2;

    localparam logic [CKS_W-1:0] CKS_DIV2  = 2'd0;
    localparam logic [CKS_W-1:0] CKS_DIV4  = 2'd1;
    localparam logic [CKS_W-1:0] CKS_DIV8  = 2'd2;
    localparam logic [CKS_W-1:0] CKS_DIV16 = 2'd3;

    // True when the low (sel+1) divider bits are all ones, i.e. the next
    // increment completes one full period of the selected rate.
    function automatic logic tap_hit(input logic [DIV_W-1:0] div,
                                     input logic [CKS_W-1:0] sel);
        logic [DIV_W:0]   full;
        logic [DIV_W-1:0] mask;
        full = ({{DIV_W{1'b0}}, 1'b1} << (sel + 3'd1)) - 1'b1;
        mask = full[DIV_W-1:0];
        return (div & mask) == mask;
    endfunction

endpackage

// File: rtl/timer_prescaler_if.sv
// Control/strobe bundle between a timer controller and the prescaler.
// The master side drives enable and clock select; the prescaler answers
// with the count strobe and its divider value.
interface timer_prescaler_if;
    import timer_pkg::*;

    logic             en;
    logic [CKS_W-1:0] cks;
    logic             clk_ena;
    logic [DIV_W-1:0] div_cnt;

    modport master (
        output en,
        output cks,
        input  clk_ena,
        input  div_cnt
    );

    modport slave (
        input  en,
        input  cks,
        output clk_ena,
        output div_cnt
    );

endinterface

// File: rtl/timer_prescaler.sv
// Clock-enable prescaler for the 8-bit timer. A free-running divider
// produces a one-cycle strobe every 2, 4, 8 or 16 clocks. Disabling the
// prescaler or changing the select restarts the divider from zero so the
// downstream counter never sees a shortened or doubled period.
module timer_prescaler
    import timer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    timer_prescaler_if.slave  bus
);

    logic [DIV_W-1:0] div;
    logic [CKS_W-1:0] cks_q;
    logic             clk_ena_q;

    // Divider, active select and registered strobe; disable beats select change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div       <= '0;
            cks_q     <= CKS_DIV2;
            clk_ena_q <= 1'b0;
        end else if (!bus.en) begin
            div       <= '0;
            cks_q     <= bus.cks;
            clk_ena_q <= 1'b0;
        end else if (bus.cks != cks_q) begin
            div       <= '0;
            cks_q     <= bus.cks;
            clk_ena_q <= 1'b0;
        end else begin
            div       <= div + 1'b1;
            clk_ena_q <= tap_hit(div, cks_q);
        end
    end

    assign bus.clk_ena = clk_ena_q;
    assign bus.div_cnt = div;

endmodule
